// File: rtl/passcode_ctrl_if.sv
// Keypad-side and status signals of the door-lock passcode controller.
// The controller attaches through the slave modport; the driver of keypad events uses master.
interface passcode_ctrl_if;
    logic       key_valid;
    logic [3:0] digit_in;
    logic       enter_i;
    logic       clear_i;
    logic       setpw_i;
    logic       shuffle_init_o;
    logic       unlock_o;
    logic       alarm_o;
    logic [2:0] state_o;
    logic [3:0] digit_count_o;
    logic [1:0] fail_count_o;

    modport master (
        output key_valid,
        output digit_in,
        output enter_i,
        output clear_i,
        output setpw_i,
        input  shuffle_init_o,
        input  unlock_o,
        input  alarm_o,
        input  state_o,
        input  digit_count_o,
        input  fail_count_o
    );

    modport slave (
        input  key_valid,
        input  digit_in,
        input  enter_i,
        input  clear_i,
        input  setpw_i,
        output shuffle_init_o,
        output unlock_o,
        output alarm_o,
        output state_o,
        output digit_count_o,
        output fail_count_o
    );
endinterface

// File: rtl/passcode_ctrl.sv
// Door-lock FSM: collects keypad digits, checks them against a stored passcode, drives
// unlock/alarm, requests a keypad reshuffle before each attempt and allows passcode change.
module passcode_ctrl #(
    parameter int unsigned CODE_LEN       = 4,
    parameter logic [31:0] DEFAULT_CODE   = 32'h0000_1234,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned UNLOCK_CYCLES  = 50,
    parameter int unsigned LOCKOUT_CYCLES = 100
) (
    input logic             clk,
    input logic             rstn,
    passcode_ctrl_if.slave  bus
);

    localparam int unsigned BufW   = 4 * CODE_LEN;
    localparam int unsigned TmrMax = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                       : LOCKOUT_CYCLES;
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);

    localparam logic [BufW-1:0] DefCode     = DEFAULT_CODE[BufW-1:0];
    localparam logic [3:0]      CodeLen     = 4'(CODE_LEN);
    localparam logic [2:0]      MaxFail     = 3'(MAX_FAIL);
    localparam logic [TmrW-1:0] UnlockLoad  = TmrW'(UNLOCK_CYCLES);
    localparam logic [TmrW-1:0] LockoutLoad = TmrW'(LOCKOUT_CYCLES);
    localparam logic [TmrW-1:0] TmrOne      = TmrW'(1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StEntry   = 3'd1,
        StCheck   = 3'd2,
        StOpen    = 3'd3,
        StLockout = 3'd4,
        StSetNew  = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [BufW-1:0] buf_q, buf_d;
    logic [BufW-1:0] code_q, code_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [1:0]      fail_q, fail_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    logic            shuffle_q, shuffle_d;
    logic            started_q;

    logic            digit_ok;
    logic            cnt_full;
    logic            code_match;
    logic [2:0]      fail_inc;
    logic [BufW-1:0] buf_push;

    assign digit_ok   = bus.key_valid && (bus.digit_in <= 4'd9);
    assign cnt_full   = (cnt_q == CodeLen);
    assign code_match = cnt_full && (buf_q == code_q);
    assign fail_inc   = {1'b0, fail_q} + 3'd1;
    assign buf_push   = (buf_q << 4) | BufW'(bus.digit_in);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        fail_d  = fail_q;
        tmr_d   = tmr_q;

        unique case (state_q)
            StIdle: begin
                // clear_i still wins priority here, it just has nothing to discard
                if (bus.clear_i) begin
                    state_d = StIdle;
                end else if (bus.enter_i) begin
                    state_d = StCheck;
                end else if (digit_ok) begin
                    if (!cnt_full) begin
                        buf_d = buf_push;
                        cnt_d = cnt_q + 4'd1;
                    end
                    state_d = StEntry;
                end
            end

            StEntry: begin
                if (bus.clear_i) begin
                    state_d = StIdle;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else if (bus.enter_i) begin
                    state_d = StCheck;
                end else if (digit_ok && !cnt_full) begin
                    buf_d = buf_push;
                    cnt_d = cnt_q + 4'd1;
                end
            end

            StCheck: begin
                buf_d = '0;
                cnt_d = '0;
                if (code_match) begin
                    state_d = StOpen;
                    fail_d  = '0;
                    tmr_d   = UnlockLoad;
                end else if (fail_inc >= MaxFail) begin
                    state_d = StLockout;
                    fail_d  = fail_inc[1:0];
                    tmr_d   = LockoutLoad;
                end else begin
                    state_d = StIdle;
                    fail_d  = fail_inc[1:0];
                end
            end

            StOpen: begin
                if (bus.setpw_i) begin
                    state_d = StSetNew;
                    tmr_d   = '0;
                end else if (tmr_q <= TmrOne) begin
                    state_d = StIdle;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q - TmrOne;
                end
            end

            StLockout: begin
                if (tmr_q <= TmrOne) begin
                    state_d = StIdle;
                    fail_d  = '0;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q - TmrOne;
                end
            end

            StSetNew: begin
                if (bus.clear_i) begin
                    buf_d = '0;
                    cnt_d = '0;
                end else if (bus.enter_i) begin
                    // A short entry abandons the change and keeps the old code
                    if (cnt_full) begin
                        code_d = buf_q;
                    end
                    state_d = StIdle;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else if (digit_ok && !cnt_full) begin
                    buf_d = buf_push;
                    cnt_d = cnt_q + 4'd1;
                end
            end

            default: begin
                state_d = StIdle;
                buf_d   = '0;
                cnt_d   = '0;
                tmr_d   = '0;
            end
        endcase
    end

    // First edge out of reset also counts as an IDLE entry, so the keypad starts shuffled
    assign shuffle_d = !started_q || ((state_q != StIdle) && (state_d == StIdle));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            buf_q     <= '0;
            code_q    <= DefCode;
            cnt_q     <= '0;
            fail_q    <= '0;
            tmr_q     <= '0;
            shuffle_q <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
            fail_q    <= fail_d;
            tmr_q     <= tmr_d;
            shuffle_q <= shuffle_d;
            started_q <= 1'b1;
        end
    end

    // Decoded straight from state so both drop the moment rstn asserts
    assign bus.unlock_o       = (state_q == StOpen);
    assign bus.alarm_o        = (state_q == StLockout);
    assign bus.shuffle_init_o = shuffle_q;
    assign bus.state_o        = state_q;
    assign bus.digit_count_o  = cnt_q;
    assign bus.fail_count_o   = fail_q;

endmodule
